// File: rtl/sprite_draw_scheduler.sv
// Frame sequencer for the double-buffered sprite renderer: on a vsync swap it clears
// the back buffer, then rasterises each enabled sprite in slot order, one pixel per handshake.
module sprite_draw_scheduler #(
  parameter int         NUM_SPRITES = 4,
  parameter int         SPR_W       = 16,
  parameter int         SPR_H       = 21,
  parameter int         SCREEN_W    = 320,
  parameter int         SCREEN_H    = 240,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic [NUM_SPRITES-1:0]   spr_en,
  input  logic [9*NUM_SPRITES-1:0] spr_x,
  input  logic [8*NUM_SPRITES-1:0] spr_y,
  input  logic [3*NUM_SPRITES-1:0] spr_color,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [8:0]               px,
  output logic [7:0]               py,
  output logic [2:0]               pcolor,
  output logic                     draw_buf,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int IDX_W = $clog2(NUM_SPRITES + 1);
  localparam int DX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES);
  localparam logic [8:0]       X_MAX    = 9'(SCREEN_W - 1);
  localparam logic [7:0]       Y_MAX    = 8'(SCREEN_H - 1);
  localparam logic [DX_W-1:0]  DX_MAX   = DX_W'(SPR_W - 1);
  localparam logic [DY_W-1:0]  DY_MAX   = DY_W'(SPR_H - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_CLEAR, ST_SELECT, ST_DRAW} state_t;

  typedef struct packed {
    logic       valid;
    logic [8:0] x;
    logic [7:0] y;
  } pix_t;

  // Sums are one bit wider than the screen coordinates so an off-screen sprite never wraps back on.
  function automatic pix_t candidate(input logic [8:0] bx, input logic [7:0] by,
                                     input logic [DX_W-1:0] dx, input logic [DY_W-1:0] dy);
    logic [9:0] cx;
    logic [8:0] cy;
    pix_t       p;
    cx      = {1'b0, bx} + 10'(dx);
    cy      = {1'b0, by} + 9'(dy);
    p.valid = (cx < 10'(SCREEN_W)) && (cy < 9'(SCREEN_H));
    p.x     = cx[8:0];
    p.y     = cy[7:0];
    return p;
  endfunction

  state_t                   r_state,    w_state_nxt;
  logic [IDX_W-1:0]         r_idx,      w_idx_nxt;
  logic [NUM_SPRITES-1:0]   r_snap_en,  w_snap_en_nxt;
  logic [9*NUM_SPRITES-1:0] r_snap_x,   w_snap_x_nxt;
  logic [8*NUM_SPRITES-1:0] r_snap_y,   w_snap_y_nxt;
  logic [3*NUM_SPRITES-1:0] r_snap_c,   w_snap_c_nxt;
  logic [8:0]               r_bx,       w_bx_nxt;
  logic [7:0]               r_by,       w_by_nxt;
  logic [2:0]               r_bc,       w_bc_nxt;
  logic [DX_W-1:0]          r_dx,       w_dx_nxt;
  logic [DY_W-1:0]          r_dy,       w_dy_nxt;
  logic                     r_wr_valid, w_wr_valid_nxt;
  logic [8:0]               r_px,       w_px_nxt;
  logic [7:0]               r_py,       w_py_nxt;
  logic [2:0]               r_pcolor,   w_pcolor_nxt;
  logic                     r_draw_buf, w_draw_buf_nxt;
  logic                     r_busy,     w_busy_nxt;
  logic                     r_frame_done, w_frame_done_nxt;
  logic                     r_overrun,  w_overrun_nxt;

  logic                     w_accept;
  logic                     w_sel_en;
  logic [8:0]               w_sel_x;
  logic [7:0]               w_sel_y;
  logic [2:0]               w_sel_c;
  pix_t                     w_pix;

  assign w_accept = r_wr_valid & wr_ready;

  always_comb begin
    w_sel_en = 1'b0;
    w_sel_x  = '0;
    w_sel_y  = '0;
    w_sel_c  = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_en = r_snap_en[i];
        w_sel_x  = r_snap_x[9*i +: 9];
        w_sel_y  = r_snap_y[8*i +: 8];
        w_sel_c  = r_snap_c[3*i +: 3];
      end
    end
  end

  // NOTE: every signal driven here gets its default first; a path that skipped one would infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_snap_en_nxt  = r_snap_en;
    w_snap_x_nxt   = r_snap_x;
    w_snap_y_nxt   = r_snap_y;
    w_snap_c_nxt   = r_snap_c;
    w_bx_nxt       = r_bx;
    w_by_nxt       = r_by;
    w_bc_nxt       = r_bc;
    w_dx_nxt       = r_dx;
    w_dy_nxt       = r_dy;
    w_wr_valid_nxt = r_wr_valid;
    w_px_nxt       = r_px;
    w_py_nxt       = r_py;
    w_pcolor_nxt   = r_pcolor;
    w_draw_buf_nxt = r_draw_buf;
    w_pix          = '0;

    unique case (r_state)
      ST_WAIT: begin
        if (vsync) begin
          w_state_nxt    = ST_CLEAR;
          w_draw_buf_nxt = ~r_draw_buf;
          w_snap_en_nxt  = spr_en;
          w_snap_x_nxt   = spr_x;
          w_snap_y_nxt   = spr_y;
          w_snap_c_nxt   = spr_color;
          w_wr_valid_nxt = 1'b1;
          w_px_nxt       = '0;
          w_py_nxt       = '0;
          w_pcolor_nxt   = CLEAR_COLOR;
        end
      end

      // px/py double as the raster column/row counters while clearing.
      ST_CLEAR: begin
        if (w_accept) begin
          if (r_px == X_MAX) begin
            w_px_nxt = '0;
            if (r_py == Y_MAX) begin
              w_state_nxt    = ST_SELECT;
              w_idx_nxt      = '0;
              w_wr_valid_nxt = 1'b0;
            end else begin
              w_py_nxt = r_py + 8'd1;
            end
          end else begin
            w_px_nxt = r_px + 9'd1;
          end
        end
      end

      ST_SELECT: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_WAIT;
        end else if (!w_sel_en) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end else begin
          w_state_nxt    = ST_DRAW;
          w_bx_nxt       = w_sel_x;
          w_by_nxt       = w_sel_y;
          w_bc_nxt       = w_sel_c;
          w_dx_nxt       = '0;
          w_dy_nxt       = '0;
          w_pix          = candidate(w_sel_x, w_sel_y, '0, '0);
          w_wr_valid_nxt = w_pix.valid;
          w_px_nxt       = w_pix.x;
          w_py_nxt       = w_pix.y;
          w_pcolor_nxt   = w_sel_c;
        end
      end

      // A clipped pixel (wr_valid low) advances on its own without a handshake.
      ST_DRAW: begin
        if (w_accept || !r_wr_valid) begin
          if ((r_dx == DX_MAX) && (r_dy == DY_MAX)) begin
            w_state_nxt    = ST_SELECT;
            w_idx_nxt      = r_idx + IDX_W'(1);
            w_wr_valid_nxt = 1'b0;
          end else begin
            if (r_dx == DX_MAX) begin
              w_dx_nxt = '0;
              w_dy_nxt = r_dy + DY_W'(1);
            end else begin
              w_dx_nxt = r_dx + DX_W'(1);
            end
            w_pix          = candidate(r_bx, r_by, w_dx_nxt, w_dy_nxt);
            w_wr_valid_nxt = w_pix.valid;
            w_px_nxt       = w_pix.x;
            w_py_nxt       = w_pix.y;
          end
        end
      end

      default: w_state_nxt = ST_WAIT;
    endcase

    w_busy_nxt       = (w_state_nxt != ST_WAIT);
    w_frame_done_nxt = (w_state_nxt == ST_SELECT) && (w_idx_nxt == LAST_IDX);
    w_overrun_nxt    = vsync && (r_state != ST_WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_WAIT;
      r_idx        <= '0;
      r_snap_en    <= '0;
      r_snap_x     <= '0;
      r_snap_y     <= '0;
      r_snap_c     <= '0;
      r_bx         <= '0;
      r_by         <= '0;
      r_bc         <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_wr_valid   <= 1'b0;
      r_px         <= '0;
      r_py         <= '0;
      r_pcolor     <= '0;
      r_draw_buf   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_snap_en    <= w_snap_en_nxt;
      r_snap_x     <= w_snap_x_nxt;
      r_snap_y     <= w_snap_y_nxt;
      r_snap_c     <= w_snap_c_nxt;
      r_bx         <= w_bx_nxt;
      r_by         <= w_by_nxt;
      r_bc         <= w_bc_nxt;
      r_dx         <= w_dx_nxt;
      r_dy         <= w_dy_nxt;
      r_wr_valid   <= w_wr_valid_nxt;
      r_px         <= w_px_nxt;
      r_py         <= w_py_nxt;
      r_pcolor     <= w_pcolor_nxt;
      r_draw_buf   <= w_draw_buf_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign wr_valid   = r_wr_valid;
  assign px         = r_px;
  assign py         = r_py;
  assign pcolor     = r_pcolor;
  assign draw_buf   = r_draw_buf;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler on a reduced 64x48 screen: table-driven frames
// checked against a bench-side framebuffer model, plus overrun and reset sequences.
module tb_sprite_draw_scheduler;

  localparam int NS    = 4;
  localparam int SW    = 64;
  localparam int SH    = 48;
  localparam int SPW   = 16;
  localparam int SPH   = 21;
  localparam int P     = SW * SH;
  localparam int LIMIT = 20000;

  logic              clk = 1'b0;
  logic              reset, vsync, wr_ready;
  logic [NS-1:0]     spr_en;
  logic [9*NS-1:0]   spr_x;
  logic [8*NS-1:0]   spr_y;
  logic [3*NS-1:0]   spr_color;
  logic              wr_valid, draw_buf, busy, frame_done, overrun;
  logic [8:0]        px;
  logic [7:0]        py;
  logic [2:0]        pcolor;

  sprite_draw_scheduler #(
    .NUM_SPRITES(NS), .SPR_W(SPW), .SPR_H(SPH),
    .SCREEN_W(SW), .SCREEN_H(SH), .CLEAR_COLOR(3'b000)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_color(spr_color),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .px(px), .py(py), .pcolor(pcolor),
    .draw_buf(draw_buf), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] pack_w(input int x, input int y, input int c);
    return {9'(x), 8'(y), 3'(c)};
  endfunction

  // Write monitor: samples on the falling edge, where the coming handshake is already stable.
  logic [19:0] mon_seq[$];
  logic [3:0]  mon_fb [P];
  int          mon_writes = 0, mon_idle = 0, mon_stall_err = 0, mon_range_err = 0;
  logic        prev_stall = 1'b0;
  logic [20:0] prev_out   = '0;

  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      mon_writes++;
      mon_seq.push_back({px, py, pcolor});
      if (int'(px) < SW && int'(py) < SH) mon_fb[int'(py) * SW + int'(px)] = {1'b0, pcolor};
      else mon_range_err++;
    end
    if (busy && !wr_valid) mon_idle++;
    if (prev_stall && ({wr_valid, px, py, pcolor} != prev_out)) mon_stall_err++;
    prev_stall = wr_valid && !wr_ready && !reset;
    prev_out   = {wr_valid, px, py, pcolor};
  end

  typedef struct {
    string         name;
    logic [NS-1:0] en;
    logic [9*NS-1:0] x;
    logic [8*NS-1:0] y;
    logic [3*NS-1:0] c;
    bit            stall;
    int            exp_writes;
    int            exp_cycles;
    int            exp_idle;
  } vec_t;

  vec_t        vecs[5];
  logic [19:0] ref_seq[$];
  int          model[P];
  logic        exp_buf = 1'b0;

  task automatic build_model(input int v);
    int bx, by;
    for (int i = 0; i < P; i++) model[i] = 0;
    for (int s = 0; s < NS; s++) begin
      if (vecs[v].en[s]) begin
        bx = int'(vecs[v].x[9*s +: 9]);
        by = int'(vecs[v].y[8*s +: 8]);
        for (int dy = 0; dy < SPH; dy++)
          for (int dx = 0; dx < SPW; dx++)
            if (bx + dx < SW && by + dy < SH) model[(by + dy) * SW + bx + dx] = int'(vecs[v].c[3*s +: 3]);
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!frame_done && n < LIMIT) begin
      tick();
      n++;
    end
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic run_frame(input int v);
    int cnt, mism;
    for (int i = 0; i < P; i++) mon_fb[i] = 4'hF;
    mon_seq.delete();
    mon_writes = 0;
    mon_idle   = 0;
    spr_en = vecs[v].en; spr_x = vecs[v].x; spr_y = vecs[v].y; spr_color = vecs[v].c;
    wr_ready = 1'b1;
    vsync    = 1'b1;
    tick();
    vsync   = 1'b0;
    exp_buf = ~exp_buf;
    cnt     = 1;
    check({vecs[v].name, "_draw_buf"}, draw_buf, exp_buf);
    check({vecs[v].name, "_first_valid"}, wr_valid, 1);
    check({vecs[v].name, "_first_xy"}, {px, py, pcolor}, pack_w(0, 0, 0));
    // The snapshot must make these changes invisible to the frame in flight.
    spr_en = ~spr_en;
    spr_x  = 36'({$urandom(), $urandom()});
    spr_y  = $urandom();
    spr_color = 12'($urandom());
    while (!frame_done && cnt < LIMIT) begin
      wr_ready = vecs[v].stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cnt++;
    end
    wr_ready = 1'b1;
    check({vecs[v].name, "_frame_done_seen"}, frame_done, 1);
    check({vecs[v].name, "_busy_at_done"}, busy, 1);
    if (!vecs[v].stall) check({vecs[v].name, "_cycles"}, cnt, vecs[v].exp_cycles);
    tick();
    check({vecs[v].name, "_done_pulse_end"}, frame_done, 0);
    check({vecs[v].name, "_busy_drop"}, busy, 0);
    check({vecs[v].name, "_writes"}, mon_writes, vecs[v].exp_writes);
    if (!vecs[v].stall) check({vecs[v].name, "_idle_cycles"}, mon_idle, vecs[v].exp_idle);
    build_model(v);
    mism = 0;
    for (int i = 0; i < P; i++) if (int'(mon_fb[i]) != model[i]) mism++;
    check({vecs[v].name, "_fb_mismatch_px"}, mism, 0);
  endtask

  int n;
  int seq_bad;

  initial begin
    //           name    en       x: {s3,s2,s1,s0}                    y: {s3,s2,s1,s0}              c: {s3,s2,s1,s0}         stall writes cycles idle
    vecs[0] = '{"empty",   4'b0000, 36'd0,                              32'd0,                         12'd0,                     0, 3072, 3077, 5};
    vecs[1] = '{"slot2",   4'b0100, {9'd0, 9'd20, 9'd0, 9'd0},          {8'd0, 8'd10, 8'd0, 8'd0},     {3'd0, 3'd5, 3'd0, 3'd0},  0, 3408, 3413, 5};
    vecs[2] = '{"clip",    4'b0001, {9'd0, 9'd0, 9'd0, 9'd56},          {8'd0, 8'd0, 8'd0, 8'd40},     {3'd0, 3'd0, 3'd0, 3'd3},  0, 3136, 3413, 277};
    vecs[3] = '{"overlap", 4'b1110, {9'd30, 9'd25, 9'd505, 9'd0},       {8'd20, 8'd15, 8'd0, 8'd0},    {3'd2, 3'd6, 3'd7, 3'd0},  0, 3744, 4085, 341};
    vecs[4] = '{"stall",   4'b0100, {9'd0, 9'd20, 9'd0, 9'd0},          {8'd0, 8'd10, 8'd0, 8'd0},     {3'd0, 3'd5, 3'd0, 3'd0},  1, 3408, 0, 0};

    reset = 1'b1; vsync = 1'b0; wr_ready = 1'b1;
    spr_en = '0; spr_x = '0; spr_y = '0; spr_color = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst_wr_valid", wr_valid, 0);
    check("rst_draw_buf", draw_buf, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pixel", {px, py, pcolor}, 0);

    for (int v = 0; v < 5; v++) begin
      run_frame(v);
      if (v == 0) begin
        check("clear_row0_end", mon_seq[SW-1], pack_w(SW-1, 0, 0));
        check("clear_row1_start", mon_seq[SW], pack_w(0, 1, 0));
        check("clear_last", mon_seq[P-1], pack_w(SW-1, SH-1, 0));
      end
      if (v == 1) ref_seq = mon_seq;
      if (v == 4) begin
        seq_bad = 0;
        for (int i = 0; i < ref_seq.size(); i++) if (i >= mon_seq.size() || mon_seq[i] != ref_seq[i]) seq_bad++;
        check("stall_seq_len", mon_seq.size(), ref_seq.size());
        check("stall_seq_diff", seq_bad, 0);
      end
    end
    check("stall_outputs_stable", mon_stall_err, 0);
    check("write_in_range", mon_range_err, 0);

    // vsync during CLEAR: overrun pulse, no swap.
    spr_en = '0;
    vsync = 1'b1; tick(); vsync = 1'b0;
    exp_buf = ~exp_buf;
    check("ovr_swap", draw_buf, exp_buf);
    for (int i = 0; i < 100; i++) tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    check("ovr_pulse", overrun, 1);
    check("ovr_no_swap", draw_buf, exp_buf);
    check("ovr_still_busy", busy, 1);
    tick();
    check("ovr_pulse_end", overrun, 0);
    wait_done(n);

    // vsync coinciding with the final SELECT cycle: overrun, frame then waits.
    vsync = 1'b1; tick(); vsync = 1'b0;
    check("late_vsync_overrun", overrun, 1);
    check("late_vsync_no_swap", draw_buf, exp_buf);
    check("late_vsync_idle", busy, 0);
    for (int i = 0; i < 5; i++) tick();
    check("late_vsync_still_wait", {busy, wr_valid}, 0);

    // Next vsync swaps; then reset while a sprite is being drawn.
    spr_en = vecs[1].en; spr_x = vecs[1].x; spr_y = vecs[1].y; spr_color = vecs[1].c;
    vsync = 1'b1; tick(); vsync = 1'b0;
    exp_buf = ~exp_buf;
    check("next_vsync_swap", draw_buf, exp_buf);
    check("next_vsync_busy", busy, 1);
    n = 0;
    while (!(wr_valid && pcolor == 3'd5) && n < LIMIT) begin
      tick();
      n++;
    end
    check("reached_draw", {wr_valid, pcolor}, {1'b1, 3'd5});
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("midreset_wr_valid", wr_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_draw_buf", draw_buf, 0);
    check("midreset_pixel", {px, py, pcolor}, 0);
    for (int i = 0; i < 3; i++) tick();
    check("midreset_stays_wait", busy, 0);
    vsync = 1'b1; tick(); vsync = 1'b0;
    check("post_reset_swap", draw_buf, 1);
    check("post_reset_first", {wr_valid, px, py, pcolor}, {1'b1, pack_w(0, 0, 0)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
